// File: rtl/matmul_seq.sv
// matmul_seq: sequential matrix-product controller.
//
// Computes C = A x B for Ndata x Ndata unsigned matrices one element at a time.
// The block does no arithmetic itself. For each element it presents row i of A
// and column j of B to an external combinational scalar-product datapath. It
// then captures that datapath's result and streams it out with a valid/ready
// handshake in row-major order.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a product (sampled only in IDLE)
//   abort      synchronous cancel of the run in progress
//   A_mat      matrix A, row-major, element [r][k] at [(r*Ndata+k)*Nbits +: Nbits]
//   B_mat      matrix B, same packing
//   sp_a       row i of latched A to the datapath (element k in slot k)
//   sp_b       column j of latched B to the datapath (B[k][j] in slot k)
//   sp_out     datapath result, sum of sp_a[k]*sp_b[k] modulo 2^(2*Nbits)
//   res_valid  result valid
//   res_ready  consumer ready
//   res_data   C[res_row][res_col]
//   res_row    row index of res_data
//   res_col    column index of res_data
//   busy       high outside IDLE
//   done       one-cycle pulse after the last result is accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; matrices are latched on the start edge
// ISSUE | operands for (i,j) on sp_a/sp_b; sp_out captured at the edge
// HOLD  | result presented; waits for res_ready, then steps (i,j)
// DONE  | done pulse for one cycle, then back to IDLE

module matmul_seq #(
  parameter int Ndata = 4,
  parameter int Nbits = 8,
  localparam int IW = (Ndata > 1) ? $clog2(Ndata) : 1,
  localparam int MW = Nbits * Ndata * Ndata,
  localparam int VW = Nbits * Ndata,
  localparam int DW = 2 * Nbits
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [MW-1:0] A_mat,
  input  logic [MW-1:0] B_mat,
  output logic [VW-1:0] sp_a,
  output logic [VW-1:0] sp_b,
  input  logic [DW-1:0] sp_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [IW-1:0] res_row,
  output logic [IW-1:0] res_col,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] LAST = IW'(Ndata - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [IW-1:0] res_row_q, res_row_d;
  logic [IW-1:0] res_col_q, res_col_d;

  // Operand selection uses constant-index slices compared against the
  // counters, so no variable part-select arithmetic is needed.
  always_comb begin
    sp_a = '0;
    sp_b = '0;
    for (int r = 0; r < Ndata; r++) begin
      for (int k = 0; k < Ndata; k++) begin
        if (IW'(r) == i_q) begin
          sp_a[k*Nbits +: Nbits] = a_q[(r*Ndata + k)*Nbits +: Nbits];
        end
        if (IW'(r) == j_q) begin
          sp_b[k*Nbits +: Nbits] = b_q[(k*Ndata + r)*Nbits +: Nbits];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_row_d   = res_row_q;
    res_col_d   = res_col_q;

    case (state_q)
      S_IDLE: begin
        // abort is ignored here, so start wins when both are high.
        if (start) begin
          a_d     = A_mat;
          b_d     = B_mat;
          i_d     = '0;
          j_d     = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (abort) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          res_data_d  = sp_out;
          res_row_d   = i_q;
          res_col_d   = j_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (abort) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          if ((i_q == LAST) && (j_q == LAST)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (j_q == LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_row   = res_row_q;
  assign res_col   = res_col_q;
  assign busy      = (state_q != S_IDLE);
  // An abort that lands in DONE suppresses the pulse for that cycle.
  assign done      = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;

  localparam int N  = 4;
  localparam int NB = 8;
  localparam int RW = 2;
  localparam int DW = 16;
  localparam int MW = NB * N * N;
  localparam int VW = NB * N;

  logic          clk, rst, start, abort, res_ready;
  logic [MW-1:0] A_mat, B_mat;
  logic [VW-1:0] sp_a, sp_b;
  logic [DW-1:0] sp_out;
  logic          res_valid, busy, done;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_row, res_col;

  matmul_seq #(.Ndata(N), .Nbits(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .A_mat(A_mat), .B_mat(B_mat), .sp_a(sp_a), .sp_b(sp_b), .sp_out(sp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
  );

  // External scalar-product datapath.
  logic [DW-1:0] acc;
  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      acc = acc + (DW'(sp_a[k*NB +: NB]) * DW'(sp_b[k*NB +: NB]));
    end
  end
  assign sp_out = acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [DW-1:0] data;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   stall_seen = 0;
  bit   stall_mode = 0;
  bit   abort_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Consumer ready: stalls result (1,2) for 5 cycles, or blocks (2,0) for abort test.
  int stall_cnt = 0;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) stall_cnt = 0;
      if (stall_mode && res_valid && res_row == 2'd1 && res_col == 2'd2 && stall_cnt < 5) begin
        res_ready = 1'b0;
        stall_cnt++;
      end else if (abort_mode && res_valid && res_row == 2'd2 && res_col == 2'd0) begin
        res_ready = 1'b0;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  int   last_hs = -1;
  int   stall_cycles = 0;
  bit   held_v = 0;
  res_t held;
  bit   prev_done = 0;
  always @(negedge clk) begin
    if (rst || !busy) last_hs = -1;
    if (!rst && res_valid) begin
      if (held_v) begin
        chk("hold_data", res_data, held.data);
        chk("hold_row", res_row, held.row);
        chk("hold_col", res_col, held.col);
      end
      if (stall_mode && res_row == 2'd1 && res_col == 2'd2) chk("stall_data_7", res_data, 7);
      if (!res_ready) begin
        stall_cycles++;
      end else begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got row %0d col %0d data %0d, expected no result",
                   res_row, res_col, res_data);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_row", res_row, e.row);
          chk("res_col", res_col, e.col);
          chk("res_data", res_data, e.data);
        end
        if (stall_mode && res_row == 2'd1 && res_col == 2'd2) begin
          chk("stall_cycles", stall_cycles, 5);
          stall_seen++;
        end
        if (!stall_mode && last_hs >= 0) chk("throughput_gap", cyc - last_hs, 2);
        last_hs = cyc;
        stall_cycles = 0;
      end
    end else begin
      stall_cycles = 0;
    end
    held_v = !rst && res_valid && !res_ready;
    held = '{row: res_row, col: res_col, data: res_data};
    if (done) begin
      done_cnt++;
      chk("done_after_last_hs", cyc, last_hs + 1);
      chk("done_sb_empty", exp_q.size(), 0);
      if (prev_done) chk("done_one_cycle", 1, 0);
    end
    prev_done = done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] mk_ident();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N + r)*NB +: NB] = 8'd1;
    return m;
  endfunction

  function automatic logic [MW-1:0] mk_b();
    logic [MW-1:0] m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N + c)*NB +: NB] = NB'(4*r + c + 1);
    return m;
  endfunction

  // kind 0: identity x B -> 4r+c+1; kind 1: all-255 -> 63492.
  task automatic push_run(input int kind, input int nres);
    for (int n = 0; n < nres; n++) begin
      res_t e;
      e.row  = RW'(n / N);
      e.col  = RW'(n % N);
      e.data = (kind == 0) ? DW'(n + 1) : DW'(63492);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit with_abort);
    A_mat = a;
    B_mat = b;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    tick();
  endtask

  logic [MW-1:0] m_id, m_b, m_ff;

  initial begin
    m_id = mk_ident();
    m_b  = mk_b();
    m_ff = '1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; A_mat = '0; B_mat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", res_data, 0);
    chk("rst_row", res_row, 0);
    chk("rst_col", res_col, 0);
    chk("rst_sp_a", sp_a, 0);
    rst = 1'b0;
    tick();

    // Identity x B, free-running consumer; abort in IDLE is a no-op.
    abort = 1'b1;
    tick();
    chk("idle_abort_busy", busy, 0);
    abort = 1'b0;
    push_run(0, 16);
    do_start(m_id, m_b, 0);
    chk("lat_e1_busy", busy, 1);
    chk("lat_e1_valid", res_valid, 0);
    tick();
    chk("lat_e2_valid", res_valid, 1);
    chk("lat_e2_rowcol", {res_row, res_col}, 0);
    wait_done("run1");
    chk("run1_done_cnt", done_cnt, 1);
    chk("run1_busy", busy, 0);

    // Backpressure on (1,2).
    stall_mode = 1;
    push_run(0, 16);
    do_start(m_id, m_b, 0);
    wait_done("run2");
    stall_mode = 0;
    chk("run2_done_cnt", done_cnt, 2);
    chk("run2_stall_seen", stall_seen, 1);

    // All 255: wraps modulo 2^16.
    push_run(1, 16);
    do_start(m_ff, m_ff, 0);
    wait_done("run3");
    chk("run3_done_cnt", done_cnt, 3);

    // start with new A/B during HOLD must be ignored.
    push_run(0, 16);
    do_start(m_id, m_b, 0);
    repeat (4) tick();
    for (int k = 0; k < 5 && !res_valid; k++) tick();
    chk("run4_in_hold", res_valid, 1);
    A_mat = m_ff;
    B_mat = m_ff;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run4_still_busy", busy, 1);
    wait_done("run4");
    chk("run4_done_cnt", done_cnt, 4);

    // Abort while (2,0) is held.
    abort_mode = 1;
    push_run(0, 8);
    do_start(m_id, m_b, 0);
    for (int k = 0; k < 100; k++) begin
      if (res_valid && res_row == 2'd2 && res_col == 2'd0) break;
      tick();
    end
    chk("abort_at_20", {res_valid, res_row, res_col}, {1'b1, 2'd2, 2'd0});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    abort_mode = 0;
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_done_cnt", done_cnt, 4);
    chk("abort_sb_empty", exp_q.size(), 0);
    push_run(0, 16);
    do_start(m_id, m_b, 0);
    tick();
    chk("restart_first", {res_valid, res_row, res_col}, {1'b1, 2'd0, 2'd0});
    wait_done("run5");
    chk("run5_done_cnt", done_cnt, 5);

    // Reset in the middle of ISSUE.
    do_start(m_id, m_b, 0);
    chk("pre_rst_issue", {busy, res_valid}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_rowcol", {res_row, res_col}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);
    // start and abort together in IDLE: start is taken.
    push_run(0, 16);
    do_start(m_id, m_b, 1);
    chk("post_rst_e1", {busy, res_valid}, 2'b10);
    tick();
    chk("post_rst_e2", {res_valid, res_row, res_col}, {1'b1, 2'd0, 2'd0});
    wait_done("run6");
    chk("run6_done_cnt", done_cnt, 6);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
